// File: rtl/fsm_par_mux_dbi.sv
// Packet-checking FSM mux: validates header and 4-bit sequence number, forwards
// accepted packets with data-bus inversion, and counts bad packets (saturating).
module fsm_par_mux_dbi #(
  parameter int          BUS_SIZE  = 16,
  parameter logic [3:0]  HEADER    = 4'hF,
  parameter int          RECOVER   = 2,
  parameter int          ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bus_valid_in,
  input  logic [BUS_SIZE-1:0]  bus_data_in,
  output logic [BUS_SIZE-1:0]  bus_data_out,
  output logic                 bus_valid_out,
  output logic                 dbi_out,
  output logic                 error,
  output logic [4:0]           state,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int RUN_W  = $clog2(RECOVER + 1);
  localparam int DIST_W = $clog2(BUS_SIZE + 1);

  typedef enum logic [4:0] {
    S_RESET   = 5'b00001,
    S_FIRST   = 5'b00010,
    S_REG     = 5'b00100,
    S_F_ERR   = 5'b01000,
    S_SEQ_ERR = 5'b10000
  } state_t;

  state_t               r_state;
  logic                 r_error;
  logic [3:0]           r_exp_seq;
  logic [RUN_W-1:0]     r_run;
  logic [BUS_SIZE-1:0]  r_data_out;
  logic                 r_valid_out;
  logic                 r_dbi;
  logic [ERR_CNT_W-1:0] r_err_count;

  state_t               w_nxt_state;
  logic [3:0]           w_nxt_exp_seq;
  logic [RUN_W-1:0]     w_nxt_run;
  logic [RUN_W-1:0]     w_run_inc;
  logic                 w_bad;
  logic                 w_fwd;
  logic                 w_good_hdr;
  logic [3:0]           w_seq;
  logic [BUS_SIZE-1:0]  w_diff;
  logic [DIST_W-1:0]    w_dist;
  logic                 w_invert;

  assign w_good_hdr = (bus_data_in[BUS_SIZE-1 -: 4] == HEADER);
  assign w_seq      = bus_data_in[3:0];
  assign w_run_inc  = r_run + RUN_W'(1);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_exp_seq = r_exp_seq;
    w_nxt_run     = r_run;
    w_bad         = 1'b0;
    case (r_state)
      S_RESET: w_nxt_state = S_FIRST;
      S_FIRST, S_REG: begin
        if (bus_valid_in) begin
          if (!w_good_hdr) begin
            w_nxt_state = S_F_ERR;
            w_nxt_run   = '0;
            w_bad       = 1'b1;
          end else if (r_state == S_REG && w_seq != r_exp_seq) begin
            w_nxt_state = S_SEQ_ERR;
            w_nxt_run   = '0;
            w_bad       = 1'b1;
          end else begin
            w_nxt_state   = S_REG;
            w_nxt_exp_seq = w_seq + 4'd1;
          end
        end
      end
      S_F_ERR, S_SEQ_ERR: begin
        if (bus_valid_in) begin
          if (w_good_hdr && (r_run == '0 || w_seq == r_exp_seq)) begin
            w_nxt_exp_seq = w_seq + 4'd1;
            if (w_run_inc == RUN_W'(RECOVER)) begin
              w_nxt_state = S_REG;
              w_nxt_run   = '0;
            end else begin
              w_nxt_run = w_run_inc;
            end
          end else begin
            w_nxt_run   = '0;
            w_bad       = 1'b1;
            w_nxt_state = w_good_hdr ? S_SEQ_ERR : S_F_ERR;
          end
        end
      end
      default: w_nxt_state = S_RESET;
    endcase
  end

  assign w_fwd = bus_valid_in && (w_nxt_state == S_REG);

  // Hamming distance against the registered output, not the previous raw input.
  assign w_diff = bus_data_in ^ r_data_out;
  always_comb begin
    w_dist = '0;
    for (int i = 0; i < BUS_SIZE; i++) w_dist = w_dist + DIST_W'(w_diff[i]);
  end
  assign w_invert = (w_dist > DIST_W'(BUS_SIZE / 2));

  // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_RESET;
      r_error     <= 1'b0;
      r_exp_seq   <= '0;
      r_run       <= '0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
      r_dbi       <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_error     <= (w_nxt_state == S_F_ERR) || (w_nxt_state == S_SEQ_ERR);
      r_exp_seq   <= w_nxt_exp_seq;
      r_run       <= w_nxt_run;
      r_valid_out <= w_fwd;
      if (w_fwd) begin
        r_data_out <= w_invert ? ~bus_data_in : bus_data_in;
        r_dbi      <= w_invert;
      end
      if (w_bad && r_err_count != '1) r_err_count <= r_err_count + ERR_CNT_W'(1);
    end
  end

  assign state         = r_state;
  assign error         = r_error;
  assign bus_data_out  = r_data_out;
  assign bus_valid_out = r_valid_out;
  assign dbi_out       = r_dbi;
  assign err_count     = r_err_count;

endmodule

// File: doc/fsm_par_mux_dbi.md
# fsm_par_mux_dbi

Parametrised successor to the single-bus packet-checking FSM mux. It checks each valid bus word for a header and a 4-bit sequence number and walks a one-hot state machine through reset, first-packet, regular and error states. Accepted packets are forwarded with data-bus inversion (DBI) to cut output toggles. It adds a valid handshake, configurable consecutive-packet error recovery and a saturating error counter, and sits between the bus source and the downstream datapath.

## Interface
- BUS_SIZE, 16: bus width in bits; must be even and >= 8.
- HEADER, 4'hF: required value of bus_data_in[BUS_SIZE-1 -: 4].
- RECOVER, 2: consecutive good packets needed to leave an error state; must be >= 1.
- ERR_CNT_W, 8: width of err_count.
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- bus_valid_in  in  1  bus_data_in holds a packet this cycle.
- bus_data_in  in  BUS_SIZE  packet; [BUS_SIZE-1 -: 4] is the header, [3:0] is the sequence number.
- bus_data_out  out  BUS_SIZE  forwarded packet, possibly inverted.
- bus_valid_out  out  1  bus_data_out was updated this cycle.
- dbi_out  out  1  bus_data_out carries the inverted packet.
- error  out  1  state is F_ERR or SEQ_ERR.
- state  out  5  one-hot: RESET 5'b00001, FIRST_PKT 5'b00010, REG_PKT 5'b00100, F_ERR 5'b01000, SEQ_ERR 10000.
- err_count  out  ERR_CNT_W  saturating count of bad packets.

## Operation
- Reset values while reset is high: state=RESET; bus_data_out=0; bus_valid_out=0; dbi_out=0; error=0; err_count=0. Internal exp_seq=0 and run=0.
- RESET goes to FIRST_PKT unconditionally on the first edge with reset low.
- A cycle with bus_valid_in=0 changes nothing except clearing bus_valid_out.
- A valid packet is good_hdr when its header == HEADER. seq = bus_data_in[3:0].
- FIRST_PKT, valid packet:
  - If !good_hdr: go to F_ERR.
  - Otherwise: set exp_seq=seq+1 and go to REG_PKT.
- REG_PKT, valid packet. Header check has priority over the sequence check.
  - If !good_hdr: go to F_ERR.
  - Else if seq != exp_seq: go to SEQ_ERR.
  - Else: stay in REG_PKT and exp_seq++.
- Entering an error state clears run.
- F_ERR or SEQ_ERR, valid packet:
  - If good_hdr and (run==0 or seq==exp_seq): run++ and exp_seq=seq+1. When run reaches RECOVER, go to REG_PKT and clear run.
  - Otherwise: clear run; go to F_ERR if !good_hdr, else SEQ_ERR.
- exp_seq is 4 bits and wraps F to 0.
- err_count increments by 1 for each valid packet that fails a check:
  - FIRST_PKT or REG_PKT: a packet that sends the FSM to F_ERR or SEQ_ERR.
  - Error states: a packet that clears run.
  - Saturates at all ones.
- Forwarding: a valid packet is forwarded iff next state is REG_PKT. This covers the packet that completes recovery. All other packets are dropped.
- DBI on forward, where d = popcount(bus_data_in ^ bus_data_out_current):
  - If d > BUS_SIZE/2: bus_data_out <= ~bus_data_in and dbi_out <= 1.
  - Otherwise: bus_data_out <= bus_data_in and dbi_out <= 0.
  - d == BUS_SIZE/2 does not invert.
- When no packet is forwarded, bus_data_out and dbi_out hold their values.
- error is registered together with state, so error == state[3] | state[4] at all times.

## Timing
- All outputs are registered, with 1-cycle latency. A packet sampled at edge N appears in state, error, err_count, bus_data_out, dbi_out and bus_valid_out after edge N.
- bus_valid_out is a single-cycle pulse per forwarded packet. Back-to-back valid packets give back-to-back pulses; there is no backpressure.
- Reset mid-operation, in any state: all outputs and internals reach their reset values after the asserting edge. No packet sampled on that edge is counted or forwarded.
- DBI compares against the bus_data_out register value before the edge, not against the raw previous input.

## Test plan
- Basic flow: reset, then valid 0xF000, 0xF001, 0xF002.
  - state goes RESET, FIRST_PKT, REG_PKT, REG_PKT.
  - Outputs 0xF000, 0xF001, 0xF002 with dbi_out=0 and one bus_valid_out pulse each.
  - error=0, err_count=0.
- Sequence wrap: 0xF00E, 0xF00F, 0xF000 with idle gaps (bus_valid_in=0) between them.
  - No error; all three forwarded.
  - bus_valid_out is low during the gaps.
- Header error and recovery (RECOVER=2): 0xF000, 0xE001, 0xF005, 0xF006.
  - 0xE001 gives F_ERR, error=1, err_count=1, nothing forwarded.
  - 0xF005 is dropped with run=1.
  - 0xF006 gives REG_PKT, error=0, output 0xF006.
- Sequence error: 0xF001, 0xF003.
  - SEQ_ERR, err_count=1.
  - Then 0xF007, 0xF009 gives run reset to 0, err_count=2, state stays SEQ_ERR.
- DBI: 0xF000 forwarded, then 0xFFF1.
  - d=9 > 8, so the output is 0x000E with dbi_out=1.
  - Then 0x0FF2 needs a good header and is rejected: F_ERR, output holds 0x000E.
- Saturation and reset (ERR_CNT_W=2): five bad-header packets.
  - err_count stops at 3.
  - Assert reset for one cycle mid-stream: all outputs go to zero and state=RESET, then FIRST_PKT on the next edge.
